// File: rtl/zion_basic_circuit_lib_rr_share_reg.sv
// Round-robin arbiter feeding one shared holding register with a valid/ready output.
// Priority pointer advances only on a load, so ungranted requesters keep their place.
module zion_basic_circuit_lib_rr_share_reg #(
    parameter int               NUM_REQ  = 4,
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0,
    parameter int               IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       iVld,
    output logic [NUM_REQ-1:0]       oRdy,
    input  logic [NUM_REQ*WIDTH-1:0] iDat,
    output logic                     oVld,
    input  logic                     iRdy,
    output logic [WIDTH-1:0]         oDat,
    output logic [IDX_W-1:0]         oIdx
);

    localparam int               CW   = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    // Illegal parameters stop elaboration, which also ends any simulation run.
    if (NUM_REQ < 2 || NUM_REQ > 32 || WIDTH < 1) begin : g_bad_param
        $error("zion_basic_circuit_lib_rr_share_reg: NUM_REQ must be 2..32 and WIDTH >= 1");
    end

    logic [IDX_W-1:0] r_ptr;
    logic             r_vld;
    logic [WIDTH-1:0] r_dat;
    logic [IDX_W-1:0] r_idx;

    logic [IDX_W-1:0]   w_grant;
    logic               w_found;
    logic [CW-1:0]      w_cand;
    logic               w_load;
    logic [NUM_REQ-1:0] w_rdy;
    logic [WIDTH-1:0]   w_dat;
    logic [IDX_W-1:0]   w_ptrNext;

    // Scan from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + CW'(k);
            if (w_cand >= CW'(NUM_REQ)) begin
                w_cand = w_cand - CW'(NUM_REQ);
            end
            if (!w_found && iVld[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_load    = (|iVld) && (!r_vld || iRdy) && !rst;
    assign w_dat     = iDat[int'(w_grant)*WIDTH +: WIDTH];
    assign w_ptrNext = (w_grant == LAST) ? '0 : w_grant + IDX_W'(1);

    always_comb begin
        w_rdy = '0;
        if (w_load) begin
            w_rdy[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_dat <= INI_DATA;
            r_idx <= '0;
            r_ptr <= '0;
        end else if (w_load) begin
            r_vld <= 1'b1;
            r_dat <= w_dat;
            r_idx <= w_grant;
            r_ptr <= w_ptrNext;
        end else if (r_vld && iRdy) begin
            r_vld <= 1'b0;
        end
    end

    assign oRdy = w_rdy;
    assign oVld = r_vld;
    assign oDat = r_dat;
    assign oIdx = r_idx;

endmodule
